// File: rtl/systolic_ctrl.sv
// Sequencer for a SIZE x SIZE systolic MAC datapath: loads SIZE beats into the
// tensor/weight FIFOs, runs the skewed compute phase, then drains results row-major.
module systolic_ctrl #(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned NBITS     = 16,
    parameter int unsigned EXTRA_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    recv_val,
    output logic                    recv_rdy,
    input  logic [SIZE-1:0]         x_fifo_full,
    input  logic [SIZE-1:0]         x_fifo_empty,
    input  logic [SIZE-1:0]         w_fifo_full,
    input  logic [SIZE-1:0]         w_fifo_empty,
    output logic [SIZE-1:0]         x_fifo_wen,
    output logic [SIZE-1:0]         w_fifo_wen,
    output logic [SIZE-1:0]         x_fifo_ren,
    output logic [SIZE-1:0]         w_fifo_ren,
    output logic                    mac_en,
    output logic                    out_en,
    output logic [$clog2(SIZE)-1:0] out_rsel,
    output logic [$clog2(SIZE)-1:0] out_csel,
    input  logic [NBITS-1:0]        s_in,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic [NBITS-1:0]        send_msg,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned SEL_W    = $clog2(SIZE);
    localparam int unsigned LAST_CYC = 3 * SIZE - 3 + EXTRA_CYC;
    localparam int unsigned CYC_W    = (LAST_CYC < 1) ? 1 : $clog2(LAST_CYC + 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] beat;
    logic [CYC_W-1:0] cyc;
    logic [SEL_W-1:0] r;
    logic [SEL_W-1:0] c;
    logic [SIZE-1:0]  ren;
    logic             accept;
    logic             xfer;
    logic             ren_fault;

    // Handshakes: a beat is written to every FIFO in the cycle it is accepted.
    assign recv_rdy = (state == S_LOAD) && !(|x_fifo_full) && !(|w_fifo_full);
    assign accept   = recv_val && recv_rdy;
    assign xfer     = (state == S_DRAIN) && send_rdy;

    assign x_fifo_wen = {SIZE{accept}};
    assign w_fifo_wen = {SIZE{accept}};

    // Lane i is read for SIZE cycles starting at cycle i, giving the diagonal skew.
    for (genvar i = 0; i < SIZE; i++) begin : g_ren
        assign ren[i] = (state == S_COMPUTE) &&
                        (cyc >= CYC_W'(i)) && (cyc < CYC_W'(i + SIZE));
    end

    assign x_fifo_ren = ren;
    assign w_fifo_ren = ren;
    assign ren_fault  = |((ren & x_fifo_empty) | (ren & w_fifo_empty));

    assign mac_en   = (state == S_COMPUTE);
    assign out_en   = (state == S_DRAIN);
    assign send_val = (state == S_DRAIN);
    assign out_rsel = r;
    assign out_csel = c;
    assign send_msg = s_in;
    assign busy     = (state != S_LOAD) || (beat != '0);

    // Phase sequencing; r/c return to zero when the drain completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
            beat  <= '0;
            cyc   <= '0;
            r     <= '0;
            c     <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (beat == SEL_W'(SIZE - 1)) begin
                            beat  <= '0;
                            cyc   <= '0;
                            state <= S_COMPUTE;
                        end else begin
                            beat <= beat + SEL_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (ren_fault) begin
                        err <= 1'b1;
                    end
                    if (cyc == CYC_W'(LAST_CYC)) begin
                        cyc   <= '0;
                        r     <= '0;
                        c     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (c == SEL_W'(SIZE - 1)) begin
                            c <= '0;
                            if (r == SEL_W'(SIZE - 1)) begin
                                r     <= '0;
                                done  <= 1'b1;
                                state <= S_LOAD;
                            end else begin
                                r <= r + SEL_W'(1);
                            end
                        end else begin
                            c <= c + SEL_W'(1);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
